// File: rtl/inst_fetch_buf.sv
`default_nettype none
// ============================================================================
//  Module      : inst_fetch_buf
//  Description : Instruction fetch front-end. Owns the fetch PC, issues one
//                outstanding word fetch at a time to instruction memory and
//                buffers returned words in a small FIFO toward decode.
//                An execute-stage redirect flushes the FIFO and restarts
//                fetch from the (word-aligned) target.
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch_buf #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jmp_en,
    input  logic [31:0] jmp_addr,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_pc_next,
    input  logic        inst_ready,
    output logic        fetch_misalign
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] c_DEPTH = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [31:0]      r_fpc;
    logic [31:0]      r_reqpc;
    logic             r_misalign;
    logic [31:0]      r_buf_data [DEPTH];
    logic [31:0]      r_buf_pc   [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic             w_pop;
    logic             w_push;
    logic             w_grant;
    logic [CNT_W-1:0] w_used;
    logic             w_space;

    // A redirect voids any same-cycle pop or push: the FIFO is flushed instead.
    assign inst_valid = (r_count != '0);
    assign w_pop      = inst_valid & inst_ready & ~jmp_en;
    assign w_push     = (r_state == S_WAIT) & mem_rvalid & ~jmp_en;
    assign w_grant    = (r_state == S_REQ) & mem_gnt;

    // Occupancy after this cycle's push/pop; nothing is in flight at any
    // point where this is used to decide whether to issue another fetch.
    assign w_used  = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    assign w_space = (w_used < c_DEPTH);

    assign mem_req        = (r_state == S_REQ);
    assign mem_addr       = r_fpc;
    assign fetch_misalign = r_misalign;

    assign inst_data    = inst_valid ? r_buf_data[r_head]          : 32'h0;
    assign inst_pc      = inst_valid ? r_buf_pc[r_head]            : 32'h0;
    assign inst_pc_next = inst_valid ? (r_buf_pc[r_head] + 32'd4)  : 32'h0;

    // Fetch state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a redirect takes priority over normal sequencing.
    // In DROP, a redirect arriving together with the stale response has
    // already consumed that response, so fetch restarts rather than waiting
    // for a response that will never come.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (jmp_en || w_space) w_state_nxt = S_REQ;
            end
            S_REQ: begin
                if (mem_gnt) w_state_nxt = jmp_en ? S_DROP : S_WAIT;
            end
            S_WAIT: begin
                if (jmp_en) begin
                    w_state_nxt = mem_rvalid ? S_REQ : S_DROP;
                end else if (mem_rvalid) begin
                    w_state_nxt = w_space ? S_REQ : S_IDLE;
                end
            end
            S_DROP: begin
                if (mem_rvalid) w_state_nxt = (jmp_en || w_space) ? S_REQ : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Fetch PC, PC of the outstanding request and the misalignment pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fpc      <= RESET_PC;
            r_reqpc    <= RESET_PC;
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= jmp_en & (jmp_addr[1:0] != 2'b00);
            if (jmp_en) begin
                r_fpc <= {jmp_addr[31:2], 2'b00};
            end else if (w_grant) begin
                r_fpc <= r_fpc + 32'd4;
            end
            if (w_grant) r_reqpc <= r_fpc;
        end
    end

    // FIFO pointers and occupancy; redirect empties the buffer.
    always_ff @(posedge clk) begin
        if (rst || jmp_en) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + PTR_W'(1);
            if (w_pop)  r_head <= r_head + PTR_W'(1);
            r_count <= w_used;
        end
    end

    // FIFO storage; contents are only visible while the entry is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf_data[r_tail] <= mem_rdata;
            r_buf_pc[r_tail]   <= r_reqpc;
        end
    end

endmodule
`default_nettype wire
